// File: rtl/vga_vmem_arbiter.sv
// Character/digit video memory shared by the VGA read path and a system writer.
// Writes are queued and committed only during vertical blanking so a frame never shows a partial update.
module vga_vmem_arbiter #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter bit          COMMIT_ANYTIME = 1'b0
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          VBlank,
    input  logic                          WrValid,
    input  logic [ADDR_W-1:0]             WrAddr,
    input  logic [DATA_W-1:0]             WrData,
    output logic                          WrReady,
    input  logic [ADDR_W-1:0]             VgaAddr,
    output logic [DATA_W-1:0]             VgaData,
    output logic [$clog2(FIFO_DEPTH):0]   Pending,
    output logic                          Committing
);

    localparam int unsigned       PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned       WORDS    = 2**ADDR_W;
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_q_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W:0]      r_count;

    logic [DATA_W-1:0]   r_mem [WORDS];
    logic [DATA_W-1:0]   r_vga_data;

    logic                w_full;
    logic                w_nonempty;
    logic                w_push;
    logic                w_pop;
    logic                w_vb;

    assign w_full     = (r_count == CNT_FULL);
    assign w_nonempty = (r_count != '0);
    assign w_push     = WrValid && !w_full;
    assign w_vb       = COMMIT_ANYTIME ? 1'b1 : VBlank;

    assign WrReady    = !w_full;
    assign Pending    = r_count;
    assign VgaData    = r_vga_data;
    // Suppressed during reset: the pop is discarded, so nothing is actually written.
    assign Committing = w_pop && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_nonempty) w_state_nxt = WAIT_VB;
            end
            WAIT_VB: begin
                if (w_vb) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                if (!w_nonempty) begin
                    w_state_nxt = IDLE;
                end else if (!w_vb) begin
                    w_state_nxt = WAIT_VB;
                end else begin
                    w_pop = 1'b1;
                    if (r_count == CNT_ONE && !w_push) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_addr[r_wptr] <= WrAddr;
            r_q_data[r_wptr] <= WrData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_pop) begin
            r_mem[r_q_addr[r_rptr]] <= r_q_data[r_rptr];
        end
    end

    // Read-before-write: a commit to the address being read shows up one edge later.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_vga_data <= '0;
        end else begin
            r_vga_data <= r_mem[VgaAddr];
        end
    end

endmodule

// File: tb/tb_vga_vmem_arbiter.sv
// Scoreboard bench for vga_vmem_arbiter: reads push expected data, a negedge monitor pops and compares.
module tb_vga_vmem_arbiter;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       VBlank = 1'b0;
    logic       WrValid = 1'b0;
    logic [3:0] WrAddr = '0;
    logic [7:0] WrData = '0;
    logic       WrReady;
    logic [3:0] VgaAddr = '0;
    logic [7:0] VgaData;
    logic [2:0] Pending;
    logic       Committing;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } rd_t;

    rd_t  exp_q[$];
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   commit_cnt = 0;
    int   c0;

    vga_vmem_arbiter #(
        .DATA_W(8),
        .ADDR_W(4),
        .FIFO_DEPTH(4),
        .COMMIT_ANYTIME(1'b0)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .VBlank(VBlank),
        .WrValid(WrValid),
        .WrAddr(WrAddr),
        .WrData(WrData),
        .WrReady(WrReady),
        .VgaAddr(VgaAddr),
        .VgaData(VgaData),
        .Pending(Pending),
        .Committing(Committing)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] d);
        rd_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        VgaAddr = a;
        rd_req  = 1'b1;
        @(posedge CLK);
        #1;
        rd_req  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        int t = 0;
        WrValid = 1'b1;
        WrAddr  = a;
        WrData  = d;
        while (!WrReady && t < 200) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (t >= 200) chk("wr_ready_timeout", 32'(WrReady), 32'd1);
        @(posedge CLK);
        #1;
        WrValid = 1'b0;
    endtask

    always @(posedge CLK) rd_vld <= rd_req;

    always @(negedge CLK) begin
        rd_t e;
        if (Committing) commit_cnt++;
        if (rd_vld) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("rd[%0d]", e.a), 32'(VgaData), 32'(e.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        RESET = 1'b0;
        #1;
        chk("rst_pending", 32'(Pending), 32'd0);
        chk("rst_wrready", 32'(WrReady), 32'd1);
        chk("rst_committing", 32'(Committing), 32'd0);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);

        // Single write held back until blanking
        wr(4'd3, 8'h5A);
        chk("t2_pending", 32'(Pending), 32'd1);
        for (int i = 0; i < 100; i++) rd(4'd3, 8'h00);
        c0 = commit_cnt;
        VBlank = 1'b1;
        tick(4);
        VBlank = 1'b0;
        chk("t2_commits", 32'(commit_cnt - c0), 32'd1);
        chk("t2_pending_after", 32'(Pending), 32'd0);
        rd(4'd3, 8'h5A);
        rd(4'd3, 8'h5A);

        // Fill the queue; the fifth request waits for a free slot
        wr(4'd0, 8'h11);
        wr(4'd1, 8'h22);
        wr(4'd2, 8'h33);
        wr(4'd3, 8'h44);
        chk("t3_pending_full", 32'(Pending), 32'd4);
        chk("t3_wrready_full", 32'(WrReady), 32'd0);
        c0 = commit_cnt;
        fork
            wr(4'd4, 8'h55);
            begin
                tick(5);
                chk("t3_held_pending", 32'(Pending), 32'd4);
                VBlank = 1'b1;
                tick(10);
                VBlank = 1'b0;
            end
        join
        chk("t3_commits", 32'(commit_cnt - c0), 32'd5);
        chk("t3_pending_after", 32'(Pending), 32'd0);
        rd(4'd0, 8'h11);
        rd(4'd1, 8'h22);
        rd(4'd2, 8'h33);
        rd(4'd3, 8'h44);
        rd(4'd4, 8'h55);

        // Blanking cut short after two commits
        wr(4'd8,  8'h81);
        wr(4'd9,  8'h82);
        wr(4'd10, 8'h83);
        wr(4'd11, 8'h84);
        tick(1);
        c0 = commit_cnt;
        VBlank = 1'b1;
        tick(3);
        VBlank = 1'b0;
        #1;
        chk("t4_no_commit_vb_low", 32'(Committing), 32'd0);
        tick(1);
        chk("t4_commits_partial", 32'(commit_cnt - c0), 32'd2);
        chk("t4_pending_partial", 32'(Pending), 32'd2);
        rd(4'd8,  8'h81);
        rd(4'd9,  8'h82);
        rd(4'd10, 8'h00);
        rd(4'd11, 8'h00);
        VBlank = 1'b1;
        #1;
        chk("t4_wait_vb_state", 32'(Committing), 32'd0);
        tick(1);
        chk("t4_commit_state", 32'(Committing), 32'd1);
        tick(4);
        VBlank = 1'b0;
        chk("t4_commits_total", 32'(commit_cnt - c0), 32'd4);
        chk("t4_pending_final", 32'(Pending), 32'd0);
        rd(4'd10, 8'h83);
        rd(4'd11, 8'h84);

        // Same address twice; read races the second commit
        wr(4'd7, 8'hAA);
        wr(4'd7, 8'hBB);
        c0 = commit_cnt;
        VBlank = 1'b1;
        rd(4'd7, 8'h00);
        rd(4'd7, 8'h00);
        rd(4'd7, 8'hAA);
        rd(4'd7, 8'hBB);
        VBlank = 1'b0;
        chk("t5_commits", 32'(commit_cnt - c0), 32'd2);
        rd(4'd7, 8'hBB);

        // Reset in the middle of a commit burst
        wr(4'd12, 8'hC1);
        wr(4'd13, 8'hC2);
        wr(4'd14, 8'hC3);
        wr(4'd15, 8'hC4);
        c0 = commit_cnt;
        VBlank = 1'b1;
        tick(2);
        chk("t6_pending_mid", 32'(Pending), 32'd3);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        VBlank = 1'b0;
        #1;
        chk("t6_pending_rst", 32'(Pending), 32'd0);
        chk("t6_wrready_rst", 32'(WrReady), 32'd1);
        chk("t6_committing_rst", 32'(Committing), 32'd0);
        chk("t6_commits", 32'(commit_cnt - c0), 32'd1);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);

        @(negedge CLK);
        #1;
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
